// File: rtl/matmul_avalon_sequencer.sv
// rtl/matmul_avalon_sequencer.sv - Avalon-MM master that loads A/B, starts the multiplier, polls status and streams C back
module matmul_avalon_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_BANKS    = 3,
    parameter int A_WORDS    = 3,
    parameter int B_WORDS    = 3,
    parameter int C_WORDS    = 9,
    parameter int BANK_AW    = 4,
    parameter int ACC_W      = 34,
    parameter int POLL_MAX   = 4096,
    localparam int BW        = N_BANKS * DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [BW-1:0]     s_data_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [ACC_W-1:0]  r_data_o,
    output logic              r_last_o,
    output logic [2:0]        avm_address_o,
    output logic              avm_chipselect_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [BW-1:0]     avm_writedata_o,
    output logic [BW/8-1:0]   avm_byteenable_o,
    input  logic [BW-1:0]     avm_readdata_i,
    input  logic              avm_waitrequest_i
);
    localparam int AB_MAX = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
    localparam int IDX_W  = $clog2(AB_MAX + 1);
    localparam int CIDX_W = $clog2(C_WORDS + 1);
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    typedef enum logic [4:0] {
        S_IDLE, S_CLR, S_RUN0, S_A_ADDR, S_A_DATA, S_A_WR, S_B_ADDR, S_B_DATA, S_B_WR,
        S_START, S_POLL, S_POLL_WAIT, S_C_ADDR, S_C_RD, S_C_WAIT, S_C_OUT, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CIDX_W-1:0]   cidx_q, cidx_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [BW-1:0]       word_q, word_d;
    logic [ACC_W-1:0]    rdata_q, rdata_d;
    logic                error_q, error_d;
    logic                cmd_ok;
    logic [BANK_AW-1:0]  bank_idx;
    logic                unused_rdata;

    assign cmd_ok       = ~avm_waitrequest_i;
    assign bank_idx     = BANK_AW'(idx_q);
    assign unused_rdata = ^avm_readdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cidx_q  <= '0;
            poll_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
            poll_q  <= poll_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Every command state advances only on the cycle its strobe is accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        poll_d  = poll_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            S_IDLE: if (go_i) begin
                error_d = 1'b0;
                idx_d   = '0;
                cidx_d  = '0;
                poll_d  = '0;
                state_d = S_CLR;
            end
            S_CLR:    if (cmd_ok) state_d = S_RUN0;
            S_RUN0:   if (cmd_ok) state_d = S_A_ADDR;
            S_A_ADDR: if (cmd_ok) state_d = S_A_DATA;
            S_A_DATA: if (s_valid_i) begin
                word_d  = s_data_i;
                state_d = S_A_WR;
            end
            S_A_WR: if (cmd_ok) begin
                if (idx_q == IDX_W'(A_WORDS - 1)) begin
                    idx_d   = '0;
                    state_d = S_B_ADDR;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_A_ADDR;
                end
            end
            S_B_ADDR: if (cmd_ok) state_d = S_B_DATA;
            S_B_DATA: if (s_valid_i) begin
                word_d  = s_data_i;
                state_d = S_B_WR;
            end
            S_B_WR: if (cmd_ok) begin
                if (idx_q == IDX_W'(B_WORDS - 1)) begin
                    idx_d   = '0;
                    state_d = S_START;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_B_ADDR;
                end
            end
            S_START: if (cmd_ok) begin
                poll_d  = '0;
                state_d = S_POLL;
            end
            S_POLL: if (cmd_ok) state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (avm_readdata_i[0]) begin
                    cidx_d  = '0;
                    state_d = S_C_ADDR;
                end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    poll_d  = poll_q + 1'b1;
                    state_d = S_POLL;
                end
            end
            S_C_ADDR: if (cmd_ok) state_d = S_C_RD;
            S_C_RD:   if (cmd_ok) state_d = S_C_WAIT;
            S_C_WAIT: begin
                rdata_d = avm_readdata_i[ACC_W-1:0];
                state_d = S_C_OUT;
            end
            S_C_OUT: if (r_ready_i) begin
                if (cidx_q == CIDX_W'(C_WORDS - 1)) begin
                    cidx_d  = '0;
                    state_d = S_DONE;
                end else begin
                    cidx_d  = cidx_q + 1'b1;
                    state_d = S_C_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on registered state only, so reset drops them without a clock.
    always_comb begin
        avm_address_o   = 3'd0;
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_writedata_o = '0;
        unique case (state_q)
            S_CLR:    begin avm_write_o = 1'b1; avm_address_o = 3'd0; avm_writedata_o = '0;                           end
            S_RUN0:   begin avm_write_o = 1'b1; avm_address_o = 3'd0; avm_writedata_o = BW'(2);                       end
            S_A_ADDR: begin avm_write_o = 1'b1; avm_address_o = 3'd4; avm_writedata_o = BW'({N_BANKS{bank_idx}});     end
            S_A_WR:   begin avm_write_o = 1'b1; avm_address_o = 3'd5; avm_writedata_o = word_q;                       end
            S_B_ADDR: begin avm_write_o = 1'b1; avm_address_o = 3'd6; avm_writedata_o = BW'({N_BANKS{bank_idx}});     end
            S_B_WR:   begin avm_write_o = 1'b1; avm_address_o = 3'd7; avm_writedata_o = word_q;                       end
            S_START:  begin avm_write_o = 1'b1; avm_address_o = 3'd0; avm_writedata_o = BW'(3);                       end
            S_POLL:   begin avm_read_o  = 1'b1; avm_address_o = 3'd1;                                                 end
            S_C_ADDR: begin avm_write_o = 1'b1; avm_address_o = 3'd2; avm_writedata_o = BW'(cidx_q);                  end
            S_C_RD:   begin avm_read_o  = 1'b1; avm_address_o = 3'd3;                                                 end
            default:  begin avm_address_o = 3'd0;                                                                     end
        endcase
        avm_chipselect_o = avm_read_o | avm_write_o;
        avm_byteenable_o = avm_write_o ? '1 : '0;
        s_ready_o        = (state_q == S_A_DATA) || (state_q == S_B_DATA);
        r_valid_o        = (state_q == S_C_OUT);
        r_data_o         = (state_q == S_C_OUT) ? rdata_q : '0;
        r_last_o         = (state_q == S_C_OUT) && (cidx_q == CIDX_W'(C_WORDS - 1));
        busy_o           = (state_q != S_IDLE);
        done_o           = (state_q == S_DONE) || (state_q == S_ERR);
        error_o          = error_q;
    end
endmodule

// File: tb/tb_matmul_avalon_sequencer.sv
// tb/tb_matmul_avalon_sequencer.sv - directed bench with a transaction-level model and slave for matmul_avalon_sequencer
module tb_matmul_avalon_sequencer;
    localparam int BW   = 48;
    localparam int PMAX = 8;

    logic clk = 1'b0, rst = 1'b1, go = 1'b0;
    logic busy, done, error, s_ready, r_valid, r_last;
    logic s_valid = 1'b0, r_ready = 1'b0, avm_waitrequest = 1'b0;
    logic [BW-1:0] s_data = '0, avm_readdata = '0, avm_writedata;
    logic [33:0] r_data;
    logic [2:0] avm_address;
    logic avm_chipselect, avm_read, avm_write;
    logic [5:0] avm_byteenable;

    matmul_avalon_sequencer #(.DATA_WIDTH(16), .N_BANKS(3), .A_WORDS(3), .B_WORDS(3), .C_WORDS(9),
                              .BANK_AW(4), .ACC_W(34), .POLL_MAX(PMAX)) dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .busy_o(busy), .done_o(done), .error_o(error),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_last_o(r_last),
        .avm_address_o(avm_address), .avm_chipselect_o(avm_chipselect), .avm_read_o(avm_read),
        .avm_write_o(avm_write), .avm_writedata_o(avm_writedata), .avm_byteenable_o(avm_byteenable),
        .avm_readdata_i(avm_readdata), .avm_waitrequest_i(avm_waitrequest));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int n_wait = 0, wcnt = 0, poll_lat = 2, s_limit = 1000, s_popped = 0;
    bit gap_mode = 0, rtog = 0, never_done = 0;
    bit mbusy = 0, merr = 0, job_err = 0;
    int done_at = -1, jobs_done = 0, r_idx = 0, n_status = 0, n_caccess = 0;
    logic [47:0] junk = 48'hA5A5_A5A5_A5A5;
    logic [47:0] stim_a[3], stim_b[3];
    logic [51:0] exp_cmd[$];
    logic [34:0] exp_r[$];
    logic [47:0] s_q[$];
    logic [33:0] model_c[9], r_seen[9];
    int exp3[9] = '{7, 2, 2, 3, 7, 3, 2, 2, 5};
    logic [47:0] sa[16], sb[16], last_addr4 = '0, rd_val = '0;
    logic [33:0] sc[16];
    logic [3:0] sa_ptr = '0, sb_ptr = '0, sc_ptr = '0;
    int polls_left = 0;
    bit rd_pend = 0, stalled = 0, w, sv, rr, st_bit;
    logic [52:0] cmd_now, saved = '0;
    logic [51:0] got, ecmd;
    logic [34:0] er;

    task automatic note(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        note(act === exp, name, act, exp);
    endtask

    function automatic logic [47:0] rep(input int i);
        logic [3:0] n;
        n = i[3:0];
        return {36'd0, n, n, n};
    endfunction

    function automatic logic [33:0] mm(input logic [47:0] a0, a1, a2, b0, b1, b2, input int e);
        logic [47:0] ra[3];
        logic [47:0] rb[3];
        logic [63:0] acc;
        ra[0] = a0; ra[1] = a1; ra[2] = a2;
        rb[0] = b0; rb[1] = b1; rb[2] = b2;
        acc = '0;
        for (int k = 0; k < 3; k++)
            acc += 64'(ra[e / 3][k*16 +: 16]) * 64'(rb[k][(e % 3)*16 +: 16]);
        return acc[33:0];
    endfunction

    // Expected bus commands, stream words and results for one job, straight from the job recipe.
    task automatic build_job();
        int npoll;
        exp_cmd.delete(); exp_r.delete(); s_q.delete();
        s_popped = 0; r_idx = 0; n_status = 0; n_caccess = 0;
        job_err = never_done;
        exp_cmd.push_back({1'b1, 3'd0, 48'd0});
        exp_cmd.push_back({1'b1, 3'd0, 48'd2});
        for (int i = 0; i < 3; i++) begin
            exp_cmd.push_back({1'b1, 3'd4, rep(i)});
            exp_cmd.push_back({1'b1, 3'd5, stim_a[i]});
            s_q.push_back(stim_a[i]);
        end
        for (int i = 0; i < 3; i++) begin
            exp_cmd.push_back({1'b1, 3'd6, rep(i)});
            exp_cmd.push_back({1'b1, 3'd7, stim_b[i]});
            s_q.push_back(stim_b[i]);
        end
        exp_cmd.push_back({1'b1, 3'd0, 48'd3});
        npoll = never_done ? PMAX : poll_lat + 1;
        for (int i = 0; i < npoll; i++) exp_cmd.push_back({1'b0, 3'd1, 48'd0});
        if (!never_done) begin
            for (int e = 0; e < 9; e++) begin
                exp_cmd.push_back({1'b1, 3'd2, 48'(e)});
                exp_cmd.push_back({1'b0, 3'd3, 48'd0});
                model_c[e] = mm(stim_a[0], stim_a[1], stim_a[2], stim_b[0], stim_b[1], stim_b[2], e);
                exp_r.push_back({e == 8, model_c[e]});
            end
        end
    endtask

    task automatic slave_accept();
        got = {avm_write, avm_address, avm_write ? avm_writedata : 48'd0};
        note(exp_cmd.size() != 0, "cmd_extra", 64'(got), 64'd0);
        if (exp_cmd.size() != 0) begin
            ecmd = exp_cmd.pop_front();
            chk("cmd", 64'(got), 64'(ecmd));
        end
        if (avm_address == 3'd2 || avm_address == 3'd3) n_caccess++;
        if (avm_write) begin
            case (avm_address)
                3'd0: begin
                    if (avm_writedata[0]) begin
                        for (int e = 0; e < 9; e++) sc[e] = mm(sa[0], sa[1], sa[2], sb[0], sb[1], sb[2], e);
                        polls_left = poll_lat;
                    end
                end
                3'd2: sc_ptr = avm_writedata[3:0];
                3'd4: begin sa_ptr = avm_writedata[3:0]; last_addr4 = avm_writedata; end
                3'd5: sa[sa_ptr] = avm_writedata;
                3'd6: begin sb_ptr = avm_writedata[3:0]; last_addr4 = avm_writedata; end
                3'd7: sb[sb_ptr] = avm_writedata;
                default: ;
            endcase
        end else begin
            if (avm_address == 3'd1) begin
                n_status++;
                if (never_done) st_bit = 1'b0;
                else if (polls_left == 0) st_bit = 1'b1;
                else begin polls_left--; st_bit = 1'b0; end
                rd_val = {junk[47:1], st_bit};
            end else begin
                rd_val = {14'h3FFF, sc[sc_ptr]};
            end
            rd_pend = 1;
        end
        if (job_err && exp_cmd.size() == 0) done_at = cyc + 2;
    endtask

    // Slave, stream source/sink and per-cycle compare, all evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        avm_readdata = rd_pend ? rd_val : junk;
        rd_pend = 0;
        if (rst) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_strobes", 64'({avm_read, avm_write, avm_chipselect, s_ready, r_valid, done, error}), 64'd0);
            exp_cmd.delete(); exp_r.delete(); s_q.delete();
            mbusy = 0; merr = 0; done_at = -1; stalled = 0; wcnt = 0;
            s_valid = 0; r_ready = 0; avm_waitrequest = 0;
        end else begin
            if (job_err && cyc == done_at) merr = 1;
            chk("busy", 64'(busy), 64'(mbusy));
            chk("done", 64'(done), 64'(cyc == done_at));
            chk("error", 64'(error), 64'(merr));
            chk("chipselect", 64'(avm_chipselect), 64'(avm_read | avm_write));
            chk("two_strobes", 64'(avm_read & avm_write), 64'd0);
            if (avm_write) chk("byteenable", 64'(avm_byteenable), 64'h3F);
            if (r_valid) chk("bus_in_c_out", 64'(avm_read | avm_write), 64'd0);
            if (!mbusy) chk("s_ready_idle", 64'(s_ready), 64'd0);
            cmd_now = {avm_write, avm_read, avm_address, avm_writedata};
            if (stalled) chk("stall_hold", 64'(cmd_now), 64'(saved));
            w = 0;
            if (avm_read | avm_write) begin
                if (wcnt < n_wait) begin w = 1; wcnt++; end else wcnt = 0;
            end else wcnt = 0;
            avm_waitrequest = w;
            stalled = (avm_read | avm_write) & w;
            saved = cmd_now;
            if ((avm_read | avm_write) && !w) slave_accept();

            sv = (s_q.size() > 0) && (s_popped < s_limit) && (!gap_mode || (cyc % 3) != 0);
            s_valid = sv;
            s_data = sv ? s_q[0] : junk;
            if (sv && s_ready) begin void'(s_q.pop_front()); s_popped++; end

            rr = !rtog || (cyc % 2) == 0;
            r_ready = rr;
            if (r_valid && rr) begin
                note(exp_r.size() != 0, "r_extra", 64'(r_data), 64'd0);
                if (exp_r.size() != 0) begin
                    er = exp_r.pop_front();
                    chk("r_data_last", 64'({r_last, r_data}), 64'(er));
                    if (r_idx < 9) r_seen[r_idx] = r_data;
                    r_idx++;
                    if (exp_r.size() == 0) done_at = cyc + 1;
                end
            end

            if (cyc == done_at) begin
                note(exp_cmd.size() == 0 && exp_r.size() == 0, "job_complete",
                     64'(exp_cmd.size() + exp_r.size()), 64'd0);
                mbusy = 0; done_at = -1; jobs_done++;
            end else if (!mbusy && go) begin
                mbusy = 1; merr = 0;
                build_job();
            end
        end
    end

    task automatic wait_jobs(input int target, input int budget);
        int n;
        n = 0;
        while (jobs_done < target && n < budget) begin @(posedge clk); n++; end
        note(jobs_done >= target, "job_timeout", 64'(jobs_done), 64'(target));
        #1;
    endtask

    task automatic run_job(input int budget);
        int target;
        target = jobs_done + 1;
        @(posedge clk); #1 go = 1;
        @(posedge clk); #1 go = 0;
        wait_jobs(target, budget);
    endtask

    task automatic set_ident();
        for (int i = 0; i < 3; i++) begin
            stim_a[i] = 48'h1 << (i * 16);
            stim_b[i] = {16'(i*3 + 3), 16'(i*3 + 2), 16'(i*3 + 1)};
        end
    endtask

    initial begin
        set_ident();
        repeat (3) @(posedge clk);
        #1 rst = 0;

        run_job(2000);
        for (int i = 0; i < 9; i++) begin
            chk("t1_model", 64'(model_c[i]), 64'(i + 1));
            chk("t1_result", 64'(r_seen[i]), 64'(i + 1));
        end

        n_wait = 3;
        run_job(4000);
        for (int i = 0; i < 9; i++) chk("t2_result", 64'(r_seen[i]), 64'(i + 1));
        n_wait = 0;

        gap_mode = 1; rtog = 1;
        stim_a[0] = {16'd0, 16'd2, 16'd1}; stim_a[1] = {16'd3, 16'd1, 16'd0}; stim_a[2] = {16'd1, 16'd0, 16'd2};
        stim_b[0] = {16'd2, 16'd0, 16'd1}; stim_b[1] = {16'd0, 16'd1, 16'd3}; stim_b[2] = {16'd1, 16'd2, 16'd0};
        run_job(4000);
        for (int i = 0; i < 9; i++) chk("t3_result", 64'(r_seen[i]), 64'(exp3[i]));
        chk("t3_addr_idx2", 64'(last_addr4), 64'h222);
        gap_mode = 0; rtog = 0;

        never_done = 1;
        run_job(2000);
        chk("t4_error", 64'(error), 64'd1);
        chk("t4_status_reads", 64'(n_status), 64'(PMAX));
        chk("t4_c_access", 64'(n_caccess), 64'd0);
        never_done = 0;

        set_ident();
        s_limit = 3;
        @(posedge clk); #1 go = 1;
        @(posedge clk); #1 go = 0;
        chk("t5_error_cleared", 64'(error), 64'd0);
        begin
            int n;
            n = 0;
            while (!(s_ready && s_popped == 3) && n < 500) begin @(posedge clk); #1; n++; end
            note(s_ready && s_popped == 3, "t5_reach_b_data", 64'(s_popped), 64'd3);
        end
        rst = 1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_outs", 64'({s_ready, avm_write, avm_read, avm_chipselect, r_valid, done}), 64'd0);
        @(posedge clk); #1 rst = 0;
        s_limit = 1000;
        run_job(2000);
        for (int i = 0; i < 9; i++) chk("t5_result", 64'(r_seen[i]), 64'(i + 1));

        begin
            int base;
            base = jobs_done;
            @(posedge clk); #1 go = 1;
            wait_jobs(base + 1, 2000);
            for (int i = 0; i < 3; i++) begin stim_a[i] = 48'hFFFF_FFFF_FFFF; stim_b[i] = 48'hFFFF_FFFF_FFFF; end
            wait_jobs(base + 2, 2000);
            go = 0;
            repeat (6) @(posedge clk);
            #1;
            chk("t6_idle_busy", 64'(busy), 64'd0);
            chk("t6_job_count", 64'(jobs_done - base), 64'd2);
            chk("t6_max_first", 64'(r_seen[0]), 64'h2_FFFA_0003);
            chk("t6_max_last", 64'(r_seen[8]), 64'h2_FFFA_0003);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
